// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: shared types and constants for the CPU memory bus
package cpu_bus_pkg;
  localparam int BUS_W = 32;
  localparam int REQ_FETCH = 0;
  localparam int REQ_DCACHE = 1;
  localparam int REQ_EXEC = 2;
  typedef enum logic [1:0] {IDLE, ISSUE, RELEASE} arb_state_t;
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: requester side and external memory side of the arbiter
interface mem_bus_arbiter_if #(parameter int LINES = 3);
  import cpu_bus_pkg::*;
  logic [LINES-1:0] req, req_wr, grant, req_ack, req_err;
  logic [LINES*BUS_W-1:0] req_addr, req_wdata;
  logic [BUS_W-1:0] rdata, addr, data_out, data_in;
  logic m_req, m_wr, m_ack, busy;
  modport master (
    output req, req_wr, req_addr, req_wdata, data_in, m_ack,
    input grant, req_ack, req_err, rdata, m_req, m_wr, addr, data_out, busy
  );
  modport slave (
    input req, req_wr, req_addr, req_wdata, data_in, m_ack,
    output grant, req_ack, req_err, rdata, m_req, m_wr, addr, data_out, busy
  );
endinterface

// File: rtl/mem_bus_arbiter_rr_picker.sv
// rr_picker: first set request at or above ptr, wrapping modulo LINES
module rr_picker #(
  parameter int LINES = 3,
  localparam int IW = LINES > 1 ? $clog2(LINES) : 1
) (
  input  logic [LINES-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic             valid_o,
  output logic [IW-1:0]    idx_o
);
  logic [IW-1:0] k;
  always_comb begin
    valid_o = 1'b0;
    idx_o = '0;
    k = '0;
    for (int i = LINES - 1; i >= 0; i--) begin
      k = IW'((int'(ptr_i) + i) % LINES);
      if (req_i[k]) begin
        valid_o = 1'b1;
        idx_o = k;
      end
    end
  end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin owner of the external memory bus with 4-phase req/ack and timeout
module mem_bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int LINES = 3,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic reset,
  mem_bus_arbiter_if.slave bus
);
  localparam int PW = LINES > 1 ? $clog2(LINES) : 1;
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  arb_state_t state_q;
  logic [LINES-1:0] grant_q, ack_q, err_q;
  logic [BUS_W-1:0] rdata_q, addr_q, dout_q, win_addr, win_wdata;
  logic m_req_q, m_wr_q, win_wr, vld, tmo;
  logic [PW-1:0] ptr_q, w_q, win, ptr_nxt;
  logic [CW-1:0] cnt_q;
  rr_picker #(.LINES(LINES)) u_pick (
    .req_i(bus.req),
    .ptr_i(ptr_q),
    .valid_o(vld),
    .idx_o(win)
  );
  always_comb begin
    win_addr = '0;
    win_wdata = '0;
    win_wr = 1'b0;
    for (int i = 0; i < LINES; i++) begin
      if (win == PW'(i)) begin
        win_addr = bus.req_addr[i*BUS_W +: BUS_W];
        win_wdata = bus.req_wdata[i*BUS_W +: BUS_W];
        win_wr = bus.req_wr[i];
      end
    end
  end
  assign ptr_nxt = w_q == PW'(LINES - 1) ? '0 : w_q + 1'b1;
  assign tmo = (TIMEOUT != 0) && (cnt_q == TMAX);
  // ack/err pulses reuse the one-hot grant, so no per-line decode is needed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q <= '0;
      w_q <= '0;
      cnt_q <= '0;
      grant_q <= '0;
      ack_q <= '0;
      err_q <= '0;
      rdata_q <= '0;
      m_req_q <= 1'b0;
      m_wr_q <= 1'b0;
      addr_q <= '0;
      dout_q <= '0;
    end else begin
      ack_q <= '0;
      err_q <= '0;
      case (state_q)
        IDLE: if (vld) begin
          state_q <= ISSUE;
          w_q <= win;
          grant_q <= LINES'(1) << win;
          m_req_q <= 1'b1;
          m_wr_q <= win_wr;
          addr_q <= win_addr;
          dout_q <= win_wr ? win_wdata : '0;
          cnt_q <= '0;
        end
        ISSUE: if (bus.m_ack || tmo) begin
          state_q <= RELEASE;
          grant_q <= '0;
          m_req_q <= 1'b0;
          m_wr_q <= 1'b0;
          addr_q <= '0;
          dout_q <= '0;
          ptr_q <= ptr_nxt;
          if (bus.m_ack) begin
            ack_q <= grant_q;
            if (!m_wr_q) rdata_q <= bus.data_in;
          end else err_q <= grant_q;
        end else if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
        RELEASE: if (!bus.m_ack) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.grant = grant_q;
  assign bus.req_ack = ack_q;
  assign bus.req_err = err_q;
  assign bus.rdata = rdata_q;
  assign bus.m_req = m_req_q;
  assign bus.m_wr = m_wr_q;
  assign bus.addr = addr_q;
  assign bus.data_out = dout_q;
  assign bus.busy = state_q != IDLE;
endmodule
